// File: rtl/useq_pkg.sv
// ---------------------------------------------------------------------------
// useq_pkg
// Shared constants for the microsequencer slice: FSM state encodings,
// next-address select (nssel) encodings, control-word field bit positions,
// the RV32 major opcodes recognised at dispatch and the micro-addresses
// each of them dispatches to.
// ---------------------------------------------------------------------------
package useq_pkg;

   // Sequencer FSM states
   localparam logic [1:0] ST_ISSUE    = 2'd0;
   localparam logic [1:0] ST_EXEC     = 2'd1;
   localparam logic [1:0] ST_WAIT_MEM = 2'd2;

   // Next-address select encodings (control-word nssel field)
   localparam logic [1:0] NS_DBIN     = 2'b00;
   localparam logic [1:0] NS_ONE      = 2'b01;
   localparam logic [1:0] NS_DISPATCH = 2'b10;
   localparam logic [1:0] NS_BRANCH   = 2'b11;

   // Control-word field positions, MSB-first
   localparam int CW_PCUP_HI  = 27;
   localparam int CW_PCUP_LO  = 26;
   localparam int CW_PCALU_HI = 25;
   localparam int CW_PCALU_LO = 24;
   localparam int CW_ASRC_HI  = 23;
   localparam int CW_ASRC_LO  = 21;
   localparam int CW_ADEST_HI = 20;
   localparam int CW_ADEST_LO = 19;
   localparam int CW_BSRC_HI  = 18;
   localparam int CW_BSRC_LO  = 16;
   localparam int CW_BDEST_HI = 15;
   localparam int CW_BDEST_LO = 14;
   localparam int CW_ALU_HI   = 13;
   localparam int CW_ALU_LO   = 11;
   localparam int CW_MEM_HI   = 10;
   localparam int CW_MEM_LO   = 8;
   localparam int CW_IRE      = 7;
   localparam int CW_NSSEL_HI = 6;
   localparam int CW_NSSEL_LO = 5;
   localparam int CW_DBIN_HI  = 4;
   localparam int CW_DBIN_LO  = 0;

   // Major opcodes recognised at dispatch
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Micro-routine entry points for each opcode
   localparam logic [4:0] UA_LUI    = 5'd2;
   localparam logic [4:0] UA_STORE  = 5'd3;
   localparam logic [4:0] UA_AUIPC  = 5'd4;
   localparam logic [4:0] UA_RTYPE  = 5'd5;
   localparam logic [4:0] UA_ITYPE  = 5'd7;
   localparam logic [4:0] UA_LOAD   = 5'd9;
   localparam logic [4:0] UA_BRANCH = 5'd12;
   localparam logic [4:0] UA_JAL    = 5'd16;

endpackage

// File: rtl/useq_dispatch.sv
// ---------------------------------------------------------------------------
// useq_dispatch
// Combinational opcode -> micro-routine entry address table.
//   opcode  : IR[6:0]
//   addr    : entry micro-address (0 for an unknown opcode)
//   illegal : high when opcode is not one of the recognised majors
// ---------------------------------------------------------------------------
module useq_dispatch
   import useq_pkg::*;
#(
   parameter int UA_W = 5
) (
   input  logic [6:0]      opcode,
   output logic [UA_W-1:0] addr,
   output logic            illegal
);

   // Table lookup; anything unrecognised lands on address 0 and is flagged
   always_comb begin
      addr    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_LUI:    addr = UA_W'(UA_LUI);
         OP_STORE:  addr = UA_W'(UA_STORE);
         OP_AUIPC:  addr = UA_W'(UA_AUIPC);
         OP_RTYPE:  addr = UA_W'(UA_RTYPE);
         OP_ITYPE:  addr = UA_W'(UA_ITYPE);
         OP_LOAD:   addr = UA_W'(UA_LOAD);
         OP_BRANCH: addr = UA_W'(UA_BRANCH);
         OP_JAL:    addr = UA_W'(UA_JAL);
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
// Walks a registered control-word ROM (a separate peer block) one
// microinstruction at a time: ISSUE presents addr, EXEC strobes the returned
// word to the datapath, WAIT_MEM stretches a memory microinstruction until
// the memory handshake completes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   controlword : ROM word registered for the last issued addr
//   opcode      : IR[6:0], used for dispatch
//   br_cond     : ALU branch-taken flag, used for conditional sequencing
//   mem_ready   : memory-complete handshake
//   addr        : registered micro-address to the ROM
//   cw_valid    : one-cycle strobe, datapath acts on controlword when high
//   illegal     : sticky unknown-opcode flag, cleared only by reset
//   instret     : count of IR loads
// ---------------------------------------------------------------------------
module microsequencer
   import useq_pkg::*;
#(
   parameter int CW_W = 28,
   parameter int UA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CW_W-1:0] controlword,
   input  logic [6:0]      opcode,
   input  logic            br_cond,
   input  logic            mem_ready,
   output logic [UA_W-1:0] addr,
   output logic            cw_valid,
   output logic            illegal,
   output logic [31:0]     instret
);

   logic [1:0]      state;
   logic [1:0]      stateNext;
   logic [2:0]      memField;
   logic            irecntl;
   logic [1:0]      nssel;
   logic [4:0]      dbin;
   logic            memStall;
   logic            exitEdge;
   logic [UA_W-1:0] addrNext;
   logic [UA_W-1:0] dispAddr;
   logic            dispIllegal;
   logic            unusedCw;

   assign memField = controlword[CW_MEM_HI:CW_MEM_LO];
   assign irecntl  = controlword[CW_IRE];
   assign nssel    = controlword[CW_NSSEL_HI:CW_NSSEL_LO];
   assign dbin     = controlword[CW_DBIN_HI:CW_DBIN_LO];

   // Datapath fields are decoded downstream; the sequencer ignores them
   assign unusedCw = ^controlword[CW_PCUP_HI:CW_ALU_LO];

   useq_dispatch #(
      .UA_W    (UA_W)
   ) u_dispatch (
      .opcode  (opcode),
      .addr    (dispAddr),
      .illegal (dispIllegal)
   );

   // A memory microinstruction stalls when the handshake has not yet
   // completed; the exit edge is the last cycle the current word is live,
   // and is the only point where opcode and br_cond are looked at
   always_comb begin
      memStall = (memField != 3'b000) && !mem_ready;
      exitEdge = ((state == ST_EXEC) && !memStall) ||
                 ((state == ST_WAIT_MEM) && mem_ready);
   end

   // Next state: ISSUE always spends exactly one cycle so the ROM can
   // register the word for the address it was just handed
   always_comb begin
      stateNext = ST_ISSUE;
      case (state)
         ST_ISSUE:    stateNext = ST_EXEC;
         ST_EXEC:     stateNext = memStall ? ST_WAIT_MEM : ST_ISSUE;
         ST_WAIT_MEM: stateNext = mem_ready ? ST_ISSUE : ST_WAIT_MEM;
         default:     stateNext = ST_ISSUE;
      endcase
   end

   // Next micro-address from the nssel field; the branch form keeps the
   // upper dbin bits and lets the ALU flag pick the even/odd target
   always_comb begin
      addrNext = '0;
      case (nssel)
         NS_DBIN:     addrNext = UA_W'(dbin);
         NS_ONE:      addrNext = UA_W'(5'd1);
         NS_DISPATCH: addrNext = dispAddr;
         NS_BRANCH:   addrNext = UA_W'({dbin[4:1], br_cond});
         default:     addrNext = '0;
      endcase
   end

   // Strobe is simply "in EXEC", so reset (which forces ISSUE) kills it
   // immediately and a fresh release never strobes the unreset ROM word
   assign cw_valid = (state == ST_EXEC);

   // Sequencer state, address, sticky illegal flag and retired-instruction
   // counter; instret counts in EXEC so a following WAIT_MEM cannot count
   // the same word twice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_ISSUE;
         addr    <= '0;
         illegal <= 1'b0;
         instret <= 32'd0;
      end else begin
         state <= stateNext;
         if (exitEdge) begin
            addr <= addrNext;
            if ((nssel == NS_DISPATCH) && dispIllegal) begin
               illegal <= 1'b1;
            end
         end
         if ((state == ST_EXEC) && irecntl) begin
            instret <= instret + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_microsequencer.sv
// ---------------------------------------------------------------------------
// tb_microsequencer
// Directed bench for the microsequencer with a small registered ROM model
// standing in for the control-word ROM.
// ---------------------------------------------------------------------------
module tb_microsequencer;

   logic        clk;
   logic        rst_n;
   logic [27:0] controlword;
   logic [6:0]  opcode;
   logic        br_cond;
   logic        mem_ready;
   logic [4:0]  addr;
   logic        cw_valid;
   logic        illegal;
   logic [31:0] instret;

   logic [27:0] rom [32];
   int          checks;
   int          errors;

   microsequencer #(
      .CW_W        (28),
      .UA_W        (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .controlword (controlword),
      .opcode      (opcode),
      .br_cond     (br_cond),
      .mem_ready   (mem_ready),
      .addr        (addr),
      .cw_valid    (cw_valid),
      .illegal     (illegal),
      .instret     (instret)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered ROM model: word for addr appears one edge after addr
   always @(posedge clk) begin
      controlword <= rom[addr];
   end

   // Control word with junk in the datapath fields so a mis-sliced decode shows up
   function automatic logic [27:0] mkWord(input logic [2:0] mem, input logic ire,
                                          input logic [1:0] ns, input logic [4:0] db);
      logic [27:0] w;
      w        = '0;
      w[27:11] = 17'h15A5A;
      w[10:8]  = mem;
      w[7]     = ire;
      w[6:5]   = ns;
      w[4:0]   = db;
      return w;
   endfunction

   task automatic applyStimulus(input logic rstN, input logic [6:0] op,
                                input logic br, input logic ready);
      rst_n     = rstN;
      opcode    = op;
      br_cond   = br;
      mem_ready = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Safety net in case the sequence ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) rom[i] = mkWord(3'b000, 1'b0, 2'b00, 5'd0);
      rom[0]  = mkWord(3'b000, 1'b0, 2'b00, 5'd23);
      rom[23] = mkWord(3'b000, 1'b1, 2'b01, 5'd0);
      rom[1]  = mkWord(3'b000, 1'b0, 2'b10, 5'd0);
      rom[5]  = mkWord(3'b000, 1'b0, 2'b11, 5'b01110);
      rom[15] = mkWord(3'b000, 1'b0, 2'b11, 5'b01110);
      rom[14] = mkWord(3'b010, 1'b1, 2'b00, 5'd20);
      rom[20] = mkWord(3'b000, 1'b0, 2'b10, 5'd0);
      rom[7]  = mkWord(3'b001, 1'b1, 2'b00, 5'd7);

      // Reset state
      applyStimulus(1'b0, 7'b0110011, 1'b0, 1'b1);
      tick(1);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_cw_valid", 32'(cw_valid), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_instret", instret, 32'd0);

      // Release: first cycle is ISSUE, strobe follows
      applyStimulus(1'b1, 7'b0110011, 1'b0, 1'b1);
      #1 checkOutput("release_no_strobe", 32'(cw_valid), 32'd0);
      tick(1);
      checkOutput("first_strobe", 32'(cw_valid), 32'd1);
      checkOutput("first_strobe_addr", 32'(addr), 32'd0);

      // Fetch loop 0 -> 23 -> 1 -> dispatch(0110011)=5
      tick(1);
      checkOutput("fetch_addr23", 32'(addr), 32'd23);
      checkOutput("issue_no_strobe", 32'(cw_valid), 32'd0);
      tick(2);
      checkOutput("fetch_addr1", 32'(addr), 32'd1);
      checkOutput("fetch_instret", instret, 32'd1);
      tick(2);
      checkOutput("dispatch_rtype", 32'(addr), 32'd5);
      checkOutput("dispatch_instret", instret, 32'd1);
      checkOutput("dispatch_legal", 32'(illegal), 32'd0);

      // Branch taken: {0111,1} = 15
      applyStimulus(1'b1, 7'b0110011, 1'b1, 1'b1);
      tick(2);
      checkOutput("branch_taken", 32'(addr), 32'd15);

      // Branch not taken: flag high during ISSUE is ignored, low at exit wins
      tick(1);
      applyStimulus(1'b1, 7'b0110011, 1'b0, 1'b1);
      tick(1);
      checkOutput("branch_not_taken", 32'(addr), 32'd14);

      // Memory handshake: ready low across EXEC and two WAIT_MEM edges
      applyStimulus(1'b1, 7'b0110011, 1'b0, 1'b0);
      tick(1);
      checkOutput("mem_exec_strobe", 32'(cw_valid), 32'd1);
      tick(1);
      checkOutput("mem_wait1_addr", 32'(addr), 32'd14);
      checkOutput("mem_wait1_strobe", 32'(cw_valid), 32'd0);
      checkOutput("mem_wait1_instret", instret, 32'd2);
      tick(1);
      checkOutput("mem_wait2_addr", 32'(addr), 32'd14);
      checkOutput("mem_wait2_strobe", 32'(cw_valid), 32'd0);
      tick(1);
      checkOutput("mem_wait3_addr", 32'(addr), 32'd14);
      checkOutput("mem_wait3_strobe", 32'(cw_valid), 32'd0);
      applyStimulus(1'b1, 7'b0110011, 1'b0, 1'b1);
      tick(1);
      checkOutput("mem_advance", 32'(addr), 32'd20);
      checkOutput("mem_instret_once", instret, 32'd2);

      // Illegal dispatch
      applyStimulus(1'b1, 7'b1111111, 1'b0, 1'b1);
      tick(2);
      checkOutput("illegal_set", 32'(illegal), 32'd1);
      checkOutput("illegal_addr", 32'(addr), 32'd0);

      // Back round the fetch loop with an I-type opcode; preload instret
      applyStimulus(1'b1, 7'b0010011, 1'b0, 1'b1);
      tick(2);
      checkOutput("loop_addr23", 32'(addr), 32'd23);
      force dut.instret = 32'hFFFFFFFF;
      #1 release dut.instret;
      tick(2);
      checkOutput("instret_wrap", instret, 32'd0);
      tick(2);
      checkOutput("dispatch_itype", 32'(addr), 32'd7);
      checkOutput("illegal_sticky", 32'(illegal), 32'd1);

      // Reset in the middle of WAIT_MEM
      applyStimulus(1'b1, 7'b0010011, 1'b0, 1'b0);
      tick(1);
      checkOutput("wait_exec_strobe", 32'(cw_valid), 32'd1);
      tick(1);
      checkOutput("wait_pending_instret", instret, 32'd1);
      #2 applyStimulus(1'b0, 7'b0010011, 1'b0, 1'b0);
      #1;
      checkOutput("async_rst_addr", 32'(addr), 32'd0);
      checkOutput("async_rst_cw_valid", 32'(cw_valid), 32'd0);
      checkOutput("async_rst_instret", instret, 32'd0);
      checkOutput("async_rst_illegal", 32'(illegal), 32'd0);
      tick(1);
      applyStimulus(1'b1, 7'b0010011, 1'b0, 1'b1);
      #1 checkOutput("rerelease_no_strobe", 32'(cw_valid), 32'd0);
      tick(1);
      checkOutput("rerelease_strobe", 32'(cw_valid), 32'd1);
      checkOutput("rerelease_instret", instret, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameter CW_W, default 28, control-word width.
REQ-002 SHALL have parameter UA_W, default 5, micro-address width.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port controlword  input  CW_W  registered ROM word for the last issued addr.
REQ-006 SHALL have port opcode  input  7  IR[6:0], sampled only at dispatch.
REQ-007 SHALL have port br_cond  input  1  branch-taken flag from ALU, sampled only on nssel=11.
REQ-008 SHALL have port mem_ready  input  1  memory-complete handshake.
REQ-009 SHALL have port addr  output  UA_W  registered micro-address to control-word ROM.
REQ-010 SHALL have port cw_valid  output  1  one-cycle strobe; datapath acts on controlword only when high.
REQ-011 SHALL have port illegal  output  1  sticky unknown-opcode flag.
REQ-012 SHALL have port instret  output  32  count of IR loads (irecntl=1 executions).

Function
REQ-013 SHALL decode controlword fields MSB-first: pcup[27:26], pcalu[25:24], asrc[23:21], adest[20:19], bsrc[18:16], bdest[15:14], alu[13:11], mem[10:8], irecntl[7], nssel[6:5], dbin[4:0].
REQ-014 SHALL implement FSM ISSUE -> EXEC -> (WAIT_MEM) -> ISSUE; ISSUE holds addr one cycle so the ROM registers its word.
REQ-015 SHALL assert cw_valid for exactly one cycle in EXEC; no strobe in ISSUE or WAIT_MEM.
REQ-016 SHALL go EXEC -> WAIT_MEM when mem!=000 and mem_ready=0; WAIT_MEM exits to ISSUE on the first cycle mem_ready=1; mem=000 or mem_ready=1 in EXEC goes straight to ISSUE.
REQ-017 SHALL compute next addr on the EXEC/WAIT_MEM exit edge: nssel 00 -> dbin; 01 -> 5'd1; 10 -> dispatch(opcode); 11 -> {dbin[4:1], br_cond}.
REQ-018 SHALL dispatch: 0110111->2, 0100011->3, 0010111->4, 0110011->5, 0010011->7, 0000011->9, 1100011->12, 1101111->16.
REQ-019 SHALL, on any other opcode at dispatch, set illegal=1 and load addr=0.
REQ-020 SHALL increment instret (mod 2^32, wraps) on the EXEC cycle of a word with irecntl=1, once per word even if WAIT_MEM follows.
REQ-021 SHALL sample br_cond/opcode on the exit edge only; changes in ISSUE or in non-final WAIT_MEM cycles have no effect.
REQ-022 SHALL give one microinstruction a minimum 2-cycle latency (ISSUE+EXEC), +N cycles for N waited cycles.

Reset
REQ-023 SHALL on rst_n=0 immediately force addr=0, state=ISSUE, cw_valid=0, illegal=0, instret=0.
REQ-024 SHALL, after rst_n release, spend first cycle in ISSUE so the unreset ROM word is never strobed.
REQ-025 SHALL abandon a pending WAIT_MEM on reset mid-operation without a cw_valid or instret update.
REQ-026 SHALL clear illegal only by reset.

Structure
REQ-027 SHALL place nssel encodings, field bit positions, opcode constants and dispatch addresses in shared package useq_pkg.
REQ-028 SHALL implement opcode->address mapping as combinational sub-module useq_dispatch (opcode in; addr, illegal out).
REQ-029 SHALL instantiate no ROM; ROM remains a separate peer block.

Verification
REQ-030 SHALL test reset: rst_n low mid-run -> addr=0, cw_valid=0, instret=0 asynchronously; first strobe two cycles after release.
REQ-031 SHALL test fetch loop: ROM words at 0 (nssel00,dbin23), 23 (irecntl1,nssel01), 1 (nssel10), opcode 0110011 -> addr sequence 0,23,1,5; instret=1.
REQ-032 SHALL test branch: word nssel11, dbin 01110; br_cond=1 -> addr 15; br_cond=0 -> addr 14.
REQ-033 SHALL test handshake: mem=010, mem_ready low 3 cycles -> cw_valid once, addr held 3 extra cycles, advances after mem_ready=1.
REQ-034 SHALL test illegal: dispatch opcode 1111111 -> illegal=1, addr=0, stays 1 through later legal dispatches.
REQ-035 SHALL test instret wrap: preload via force 32'hFFFFFFFF, one IR load -> 0.
